// File: rtl/loteria_pkg.sv
// Shared constants and entry-FSM state type for the lottery game.
package loteria_pkg;
    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] MAX_DIGIT  = 4'd9;

    typedef enum logic {
        ENTRY,
        FULL
    } entry_state_t;
endpackage

// File: rtl/debounce_key.sv
// Active-low pushbutton conditioner: 2-FF synchroniser, stability counter
// and a one-cycle pulse on the debounced press (1->0) edge.
module debounce_key #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synced level differs from the accepted
    // one, so any bounce back to the accepted level restarts it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    assign press = prev_q & ~level_q;
endmodule

// File: rtl/entrada_aposta.sv
// Bet-entry front end: conditions the three keys and assembles a 4-digit
// BCD bet, pulsing insert once a full bet is confirmed.
module entrada_aposta
    import loteria_pkg::*;
#(
    parameter int DB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       key_digit,
    input  logic       key_confirm,
    input  logic       key_clear,
    output logic [3:0] num0,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [2:0] count,
    output logic       insert,
    output logic       err
);
    logic dig_ev, conf_ev, clr_ev;

    debounce_key #(.DB_CYCLES(DB_CYCLES)) u_db_digit (
        .clk(clk), .reset(reset), .key_n(key_digit), .press(dig_ev));
    debounce_key #(.DB_CYCLES(DB_CYCLES)) u_db_confirm (
        .clk(clk), .reset(reset), .key_n(key_confirm), .press(conf_ev));
    debounce_key #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
        .clk(clk), .reset(reset), .key_n(key_clear), .press(clr_ev));

    entry_state_t                 state_q, state_d;
    logic [NUM_DIGITS-1:0][3:0]   num_q, num_d;
    logic [2:0]                   count_q, count_d;
    logic                         err_q, err_d;
    logic                         insert_q, insert_d;

    // Priority clear > confirm > digit. The insert cycle retires the bet;
    // debounce spacing keeps other events out of that cycle.
    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        count_d  = count_q;
        err_d    = err_q;
        insert_d = 1'b0;
        if (clr_ev) begin
            num_d   = '0;
            count_d = '0;
            err_d   = 1'b0;
            state_d = ENTRY;
        end else if (insert_q) begin
            count_d = '0;
            state_d = ENTRY;
        end else if (conf_ev) begin
            if (state_q == FULL) begin
                insert_d = 1'b1;
                err_d    = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (dig_ev) begin
            if (state_q == FULL || sw > MAX_DIGIT) begin
                err_d = 1'b1;
            end else begin
                if (count_q == 3'd0) begin
                    num_d    = '0;
                    num_d[0] = sw;
                end else begin
                    num_d = {num_q[NUM_DIGITS-2:0], sw};
                end
                count_d = count_q + 3'd1;
                err_d   = 1'b0;
                if (count_q == 3'(NUM_DIGITS - 1)) state_d = FULL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ENTRY;
            num_q    <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            insert_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            count_q  <= count_d;
            err_q    <= err_d;
            insert_q <= insert_d;
        end
    end

    assign num0   = num_q[0];
    assign num1   = num_q[1];
    assign num2   = num_q[2];
    assign num3   = num_q[3];
    assign count  = count_q;
    assign insert = insert_q;
    assign err    = err_q;
endmodule

// File: tb/tb_entrada_aposta.sv
// Directed vector bench for entrada_aposta with a short debounce window.
module tb_entrada_aposta;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw;
    logic       key_digit, key_confirm, key_clear;
    logic [3:0] num0, num1, num2, num3;
    logic [2:0] count;
    logic       insert, err;

    int total = 0;
    int bad   = 0;

    entrada_aposta #(.DB_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .sw(sw),
        .key_digit(key_digit), .key_confirm(key_confirm), .key_clear(key_clear),
        .num0(num0), .num1(num1), .num2(num2), .num3(num3),
        .count(count), .insert(insert), .err(err));

    always #5 clk = ~clk;

    // insert monitor: pulse count plus what count/digits read around it
    int          ins_total = 0;
    logic        ins_prev  = 1'b0;
    logic [2:0]  cnt_during, cnt_after;
    logic [15:0] num_during;
    always @(negedge clk) begin
        if (ins_prev) cnt_after = count;
        if (insert) begin
            ins_total  = ins_total + 1;
            cnt_during = count;
            num_during = {num3, num2, num1, num0};
        end
        ins_prev = insert;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // k: bit0 digit, bit1 confirm, bit2 clear; returns insert pulses seen
    task automatic press(input logic [2:0] k, output int ins);
        int start;
        start = ins_total;
        @(negedge clk);
        key_digit   = ~k[0];
        key_confirm = ~k[1];
        key_clear   = ~k[2];
        cycles(12);
        key_digit = 1'b1; key_confirm = 1'b1; key_clear = 1'b1;
        cycles(12);
        ins = ins_total - start;
    endtask

    typedef struct {
        logic [2:0]  keys;
        logic [3:0]  sw;
        logic [15:0] exp_num;
        logic [2:0]  exp_cnt;
        logic        exp_err;
        int          exp_ins;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int ins;
        vecs[0]  = '{3'b001, 4'd1, 16'h0001, 3'd1, 1'b0, 0};
        vecs[1]  = '{3'b001, 4'd2, 16'h0012, 3'd2, 1'b0, 0};
        vecs[2]  = '{3'b001, 4'd3, 16'h0123, 3'd3, 1'b0, 0};
        vecs[3]  = '{3'b001, 4'd4, 16'h1234, 3'd4, 1'b0, 0};
        vecs[4]  = '{3'b010, 4'd0, 16'h1234, 3'd0, 1'b0, 1};
        vecs[5]  = '{3'b001, 4'hA, 16'h1234, 3'd0, 1'b1, 0};
        vecs[6]  = '{3'b001, 4'd5, 16'h0005, 3'd1, 1'b0, 0};
        vecs[7]  = '{3'b001, 4'd6, 16'h0056, 3'd2, 1'b0, 0};
        vecs[8]  = '{3'b010, 4'd0, 16'h0056, 3'd2, 1'b1, 0};
        vecs[9]  = '{3'b001, 4'd7, 16'h0567, 3'd3, 1'b0, 0};
        vecs[10] = '{3'b001, 4'd8, 16'h5678, 3'd4, 1'b0, 0};
        vecs[11] = '{3'b001, 4'd9, 16'h5678, 3'd4, 1'b1, 0};
        vecs[12] = '{3'b100, 4'd0, 16'h0000, 3'd0, 1'b0, 0};

        reset = 1'b0; sw = 4'd0;
        key_digit = 1'b1; key_confirm = 1'b1; key_clear = 1'b1;
        #1;
        chk("reset_num", {num3, num2, num1, num0}, 16'h0);
        chk("reset_cnt", count, 3'd0);
        chk("reset_ins_err", {insert, err}, 2'b00);
        cycles(3);
        reset = 1'b1;
        cycles(3);

        for (int i = 0; i < 13; i++) begin
            sw = vecs[i].sw;
            press(vecs[i].keys, ins);
            chk($sformatf("v%0d_num", i), {num3, num2, num1, num0}, vecs[i].exp_num);
            chk($sformatf("v%0d_cnt", i), count, vecs[i].exp_cnt);
            chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
            chk($sformatf("v%0d_ins", i), ins, vecs[i].exp_ins);
            if (vecs[i].exp_ins == 1) begin
                chk("ins_cnt_during", cnt_during, 3'd4);
                chk("ins_num_during", num_during, 16'h1234);
                chk("ins_cnt_after", cnt_after, 3'd0);
            end
        end

        // bouncing digit key: one accept only
        sw = 4'd7;
        for (int i = 0; i < 6; i++) begin
            key_digit = ~key_digit;
            @(negedge clk);
        end
        key_digit = 1'b0;
        cycles(10);
        key_digit = 1'b1;
        cycles(12);
        chk("bounce_num", {num3, num2, num1, num0}, 16'h0007);
        chk("bounce_cnt", count, 3'd1);

        // clear + confirm together in FULL
        for (int d = 1; d <= 3; d++) begin
            sw = 4'(d);
            press(3'b001, ins);
        end
        chk("fill_cnt", count, 3'd4);
        press(3'b110, ins);
        chk("clrconf_num", {num3, num2, num1, num0}, 16'h0);
        chk("clrconf_cnt", count, 3'd0);
        chk("clrconf_ins", ins, 0);

        // reset mid-debounce with 3 digits entered
        for (int d = 1; d <= 3; d++) begin
            sw = 4'(d);
            press(3'b001, ins);
        end
        chk("pre_rst_num", {num3, num2, num1, num0}, 16'h0123);
        begin
            int start;
            start = ins_total;
            key_digit = 1'b0;
            cycles(4);
            #2 reset = 1'b0;
            #1;
            chk("rst_async_num", {num3, num2, num1, num0}, 16'h0);
            chk("rst_async_cnt", count, 3'd0);
            chk("rst_async_ins_err", {insert, err}, 2'b00);
            key_digit = 1'b1;
            cycles(3);
            reset = 1'b1;
            cycles(20);
            chk("post_rst_cnt", count, 3'd0);
            chk("post_rst_num", {num3, num2, num1, num0}, 16'h0);
            chk("post_rst_ins", ins_total - start, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
